// File: rtl/banked_sram_pingpong_pkg.sv
// Shared types, default geometry and bank-slicing helper for the
// ping-pong banked SRAM.
package pingpong_pkg;

  // State of one tile half: free for the loader, or holding a complete tile.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } half_state_e;

  localparam int unsigned NUM_BANKS_DEF  = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned BUS_WIDTH      = DATA_WIDTH_DEF * NUM_BANKS_DEF;

  // LSB position of bank 'bank' inside a concatenated bus (bank 0 in the LSBs).
  function automatic int unsigned bank_lsb(input int unsigned bank,
                                           input int unsigned width);
    return bank * width;
  endfunction

endpackage

// File: rtl/banked_sram_pingpong_if.sv
// Load/fetch bus of the ping-pong SRAM. The master drives the load and
// fetch requests; the slave (the SRAM) returns data and status.
interface banked_sram_pingpong_if
  import pingpong_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int unsigned BW = DATA_WIDTH * NUM_BANKS;

  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [BW-1:0]         load_data;
  logic [NUM_BANKS-1:0]  load_bank_mask;
  logic                  load_done;
  logic                  load_ready;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [BW-1:0]         fetch_data;
  logic                  fetch_valid;
  logic                  fetch_done;
  logic                  fetch_ready;
  logic [1:0]            occupancy;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output load_en, load_addr, load_data, load_bank_mask, load_done,
    output fetch_en, fetch_addr, fetch_done,
    input  load_ready, fetch_data, fetch_valid, fetch_ready,
    input  occupancy, err_overflow, err_underflow
  );

  modport slave (
    input  load_en, load_addr, load_data, load_bank_mask, load_done,
    input  fetch_en, fetch_addr, fetch_done,
    output load_ready, fetch_data, fetch_valid, fetch_ready,
    output occupancy, err_overflow, err_underflow
  );

endinterface

// File: rtl/banked_sram_pingpong_bank.sv
// One SRAM bank: single write port and a registered read port. The array
// itself is never reset; only the read register is cleared so the fetch
// bus comes out of reset at zero.
module banked_sram_pingpong_bank #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= {DATA_WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/banked_sram_pingpong.sv
// Double-buffered banked SRAM. The loader fills half wr_ptr while the
// fetcher reads half rd_ptr; each half is a two-state EMPTY/FULL machine
// closed by load_done and released by fetch_done.
module banked_sram_pingpong
  import pingpong_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  banked_sram_pingpong_if.slave bus
);
  localparam int unsigned BW = DATA_WIDTH * NUM_BANKS;

  logic             r_wr_ptr;
  logic             r_rd_ptr;
  half_state_e      r_state     [2];
  half_state_e      w_state_nxt [2];
  logic [1:0]       w_full;
  logic             w_load_ready;
  logic             w_fetch_ready;
  logic             w_load_acc;
  logic             w_load_close;
  logic             w_fetch_acc;
  logic             w_fetch_close;
  logic             r_fetch_valid;
  logic             r_rd_sel;
  logic             r_err_overflow;
  logic             r_err_underflow;
  logic [1:0][BW-1:0] w_rd_data;

  assign w_full[0]     = (r_state[0] == FULL);
  assign w_full[1]     = (r_state[1] == FULL);
  assign w_load_ready  = ~w_full[r_wr_ptr];
  assign w_fetch_ready = w_full[r_rd_ptr];

  assign w_load_acc    = bus.load_en    & w_load_ready;
  assign w_load_close  = bus.load_done  & w_load_ready;
  assign w_fetch_acc   = bus.fetch_en   & w_fetch_ready;
  assign w_fetch_close = bus.fetch_done & w_fetch_ready;

  // Bank array: half h is selected purely through write/read enable gating.
  for (genvar h = 0; h < 2; h++) begin : g_half
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      localparam int unsigned LSB = bank_lsb(b, DATA_WIDTH);

      banked_sram_pingpong_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_load_acc & (r_wr_ptr == 1'(h)) & bus.load_bank_mask[b]),
        .i_wr_addr (bus.load_addr),
        .i_wr_data (bus.load_data[LSB +: DATA_WIDTH]),
        .i_rd_en   (w_fetch_acc & (r_rd_ptr == 1'(h))),
        .i_rd_addr (bus.fetch_addr),
        .o_rd_data (w_rd_data[h][LSB +: DATA_WIDTH])
      );
    end
  end

  // Per-half next state; load_done and fetch_done never target the same half.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      w_state_nxt[h] = r_state[h];
      case (r_state[h])
        EMPTY: begin
          if (w_load_close && (r_wr_ptr == 1'(h))) begin
            w_state_nxt[h] = FULL;
          end else begin
            w_state_nxt[h] = EMPTY;
          end
        end
        FULL: begin
          if (w_fetch_close && (r_rd_ptr == 1'(h))) begin
            w_state_nxt[h] = EMPTY;
          end else begin
            w_state_nxt[h] = FULL;
          end
        end
        default: w_state_nxt[h] = EMPTY;
      endcase
    end
  end

  // Half states and ping-pong pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      if (w_load_close) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_fetch_close) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Fetch strobe and the half select for the output mux, both aligned with
  // the bank read registers so the read latency stays at one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_valid <= 1'b0;
      r_rd_sel      <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_rd_sel <= r_rd_ptr;
      end
    end
  end

  // Sticky protocol error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if ((bus.load_en || bus.load_done) && !w_load_ready) begin
        r_err_overflow <= 1'b1;
      end
      if ((bus.fetch_en || bus.fetch_done) && !w_fetch_ready) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign bus.load_ready    = w_load_ready;
  assign bus.fetch_ready   = w_fetch_ready;
  assign bus.fetch_valid   = r_fetch_valid;
  assign bus.fetch_data    = r_rd_sel ? w_rd_data[1] : w_rd_data[0];
  assign bus.occupancy     = {1'b0, w_full[0]} + {1'b0, w_full[1]};
  assign bus.err_overflow  = r_err_overflow;
  assign bus.err_underflow = r_err_underflow;

endmodule

// File: tb/tb_banked_sram_pingpong.sv
// Scoreboard bench for banked_sram_pingpong (4 banks x 16 bits, 16 rows).
module tb_banked_sram_pingpong;
  localparam int unsigned NB = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [63:0] exp_q [$];

  banked_sram_pingpong_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  banked_sram_pingpong #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.load_en        = 1'b0;
    bus_if.load_addr      = '0;
    bus_if.load_data      = '0;
    bus_if.load_bank_mask = '0;
    bus_if.load_done      = 1'b0;
    bus_if.fetch_en       = 1'b0;
    bus_if.fetch_addr     = '0;
    bus_if.fetch_done     = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [3:0] m, input logic done);
    bus_if.load_en        = 1'b1;
    bus_if.load_addr      = a;
    bus_if.load_data      = d;
    bus_if.load_bank_mask = m;
    bus_if.load_done      = done;
    cyc();
    idle();
  endtask

  task automatic pulse_load_done();
    bus_if.load_done = 1'b1;
    cyc();
    idle();
  endtask

  task automatic pulse_fetch_done();
    bus_if.fetch_done = 1'b1;
    cyc();
    idle();
  endtask

  // Accepted read: the expected word is queued for the monitor.
  task automatic rd(input logic [3:0] a, input logic [63:0] exp, input logic done);
    bus_if.fetch_en   = 1'b1;
    bus_if.fetch_addr = a;
    bus_if.fetch_done = done;
    exp_q.push_back(exp);
    cyc();
    idle();
  endtask

  task automatic chk_status(input string tag, input logic [1:0] occ, input logic lr,
                            input logic fr, input logic eo, input logic eu);
    chk({tag, "_occ"}, 64'(bus_if.occupancy), 64'(occ));
    chk({tag, "_load_ready"}, 64'(bus_if.load_ready), 64'(lr));
    chk({tag, "_fetch_ready"}, 64'(bus_if.fetch_ready), 64'(fr));
    chk({tag, "_err_ovf"}, 64'(bus_if.err_overflow), 64'(eo));
    chk({tag, "_err_udf"}, 64'(bus_if.err_underflow), 64'(eu));
  endtask

  // Monitor: every presented fetch result must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got valid data %h expected no read", bus_if.fetch_data);
        end else begin
          chk("sb_fetch_data", bus_if.fetch_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state.
    chk_status("reset", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_valid", 64'(bus_if.fetch_valid), 64'd0);
    chk("reset_data", bus_if.fetch_data, 64'd0);

    // Underflow: fetch on an empty buffer is dropped.
    bus_if.fetch_en   = 1'b1;
    bus_if.fetch_addr = 4'd3;
    cyc();
    idle();
    chk("udf_valid", 64'(bus_if.fetch_valid), 64'd0);
    chk("udf_data", bus_if.fetch_data, 64'd0);
    chk_status("udf", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("udf_cleared", 64'(bus_if.err_underflow), 64'd0);

    // Basic fill/drain on half 0.
    wr(4'd3, 64'h4444_3333_2222_1111, 4'b1111, 1'b0);
    chk("basic_occ_before_done", 64'(bus_if.occupancy), 64'd0);
    pulse_load_done();
    chk_status("basic_loaded", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(4'd3, 64'h4444_3333_2222_1111, 1'b0);
    chk("basic_valid", 64'(bus_if.fetch_valid), 64'd1);
    cyc();
    chk("basic_valid_drop", 64'(bus_if.fetch_valid), 64'd0);
    chk("basic_data_hold", bus_if.fetch_data, 64'h4444_3333_2222_1111);
    pulse_fetch_done();
    chk_status("basic_drained", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Masked write on half 1: banks 0 and 2 overwritten.
    wr(4'd0, 64'hAAAA_AAAA_AAAA_AAAA, 4'b1111, 1'b0);
    wr(4'd0, 64'h5555_5555_5555_5555, 4'b0101, 1'b0);
    wr(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 1'b0);
    pulse_load_done();
    rd(4'd0, 64'hAAAA_5555_AAAA_5555, 1'b1);
    chk_status("masked_drained", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Ping-pong: write together with load_done lands in half 0 before it closes.
    wr(4'd5, 64'h0505_0505_0505_0505, 4'b1111, 1'b0);
    wr(4'd1, 64'h0000_0000_0000_0001, 4'b1111, 1'b1);
    chk_status("pp_h0_full", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_if.load_en = 1'b1;
    bus_if.load_addr = 4'd1;
    bus_if.load_data = 64'h0000_0000_0000_0002;
    bus_if.load_bank_mask = 4'b1111;
    bus_if.fetch_en = 1'b1;
    bus_if.fetch_addr = 4'd1;
    exp_q.push_back(64'h0000_0000_0000_0001);
    cyc();
    idle();
    wr(4'd5, 64'hBEEF_CAFE_1234_5678, 4'b1111, 1'b0);
    // Read, fetch_done and load_done all in one cycle.
    bus_if.fetch_en = 1'b1;
    bus_if.fetch_addr = 4'd1;
    bus_if.fetch_done = 1'b1;
    bus_if.load_done = 1'b1;
    exp_q.push_back(64'h0000_0000_0000_0001);
    cyc();
    idle();
    chk_status("pp_swapped", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(4'd1, 64'h0000_0000_0000_0002, 1'b0);

    // Full and overflow: half 0 reloaded over its old contents.
    wr(4'd5, 64'h0505_0505_0505_0505, 4'b1111, 1'b1);
    chk_status("full", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    wr(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 1'b0);
    chk_status("ovf", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_load_done();
    chk_status("ovf_done_ignored", 2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(4'd5, 64'hBEEF_CAFE_1234_5678, 1'b1);
    chk_status("ovf_one_left", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    rd(4'd5, 64'h0505_0505_0505_0505, 1'b0);

    // Reset while a read is in flight at occupancy 1.
    bus_if.fetch_en = 1'b1;
    bus_if.fetch_addr = 4'd1;
    exp_q.push_back(64'h0000_0000_0000_0001);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    chk("rst_mid_valid", 64'(bus_if.fetch_valid), 64'd0);
    chk("rst_mid_data", bus_if.fetch_data, 64'd0);
    chk_status("rst_mid", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Every queued read must have been observed.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      cyc();
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
